ex_mem_stage_reg: RTL and testbench
===================================

// Module: ex_mem_stage_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register for the pipelined CPU; adds valid bit, stall/flush, flag vector.
//  Also provides EX->EX operand forwarding, load-use hazard detection and saturating stall/bubble counters.
//  Sits between the ALU/shifter stage and the data-memory stage; feeds hazard unit and decode muxes.
// PARAMETERS
//  DATA_W    16    datapath width (ALU result, B operand, forwarded data)
//  RN_W      3     register-number width (8-entry register file)
//  VSEL_W    2     write-back source select width
//  STAT_W    3     status flag vector width, {V,N,Z}
//  CNT_W     16    width of each performance counter
// PORTS
//  clk           in   1        clock, all state updates on rising edge
//  reset         in   1        synchronous, active-high
//  ex_valid      in   1        EX slot holds a real instruction
//  ex_alu        in   DATA_W   ALU result / memory address
//  ex_status     in   STAT_W   {V,N,Z} from ALU
//  ex_b          in   DATA_W   B operand (store data)
//  ex_vsel       in   VSEL_W   write-back source select
//  ex_write_num  in   RN_W     destination register
//  ex_write      in   1        register-file write enable
//  ex_mem_rd     in   1        instruction is a load
//  ex_mem_wr     in   1        instruction is a store
//  stall         in   1        hold all stage contents
//  flush         in   1        replace captured slot with a bubble
//  id_rs_a       in   RN_W     decode-stage source A register number
//  id_rs_b       in   RN_W     decode-stage source B register number
//  mem_valid     out  1        registered ex_valid
//  mem_alu, mem_status, mem_b, mem_vsel, mem_write_num  out  (widths as inputs)  registered fields
//  mem_write, mem_mem_rd, mem_mem_wr  out  1     registered, already qualified by valid
//  fwd_a_hit     out  1        forward fwd_data onto operand A
//  fwd_b_hit     out  1        forward fwd_data onto operand B
//  fwd_data      out  DATA_W   = mem_alu
//  load_use      out  1        load in MEM feeds a decode source; hazard unit must stall
//  stall_cnt     out  CNT_W    cycles spent stalled
//  bubble_cnt    out  CNT_W    bubbles loaded into stage
// BEHAVIOUR
//  - Priority per edge: reset > flush > stall > load. Nonblocking assignments only.
//  - reset: every registered output and both counters -> 0; mid-operation reset discards slot same edge.
//  - load: all mem_* <= ex_*; mem_write/mem_mem_rd/mem_mem_wr <= ex_valid & ex_*; latency 1 cycle.
//  - flush (any stall): mem_valid, mem_write, mem_mem_rd, mem_mem_wr <= 0; data fields hold old value.
//  - stall without flush: every register holds; load_use/forwarding outputs recomputed from held state.
//  - ex_valid=0 on load: captured as bubble, enables forced 0 as above.
//  - fwd_a_hit = mem_valid & mem_write & ~mem_mem_rd & (mem_write_num==id_rs_a); fwd_b_hit same with id_rs_b.
//  - load_use = mem_valid & mem_mem_rd & mem_write & (num==id_rs_a | num==id_rs_b). Combinational from regs.
//  - Store (mem_mem_wr) never forwards or raises load_use unless mem_write also set.
//  - stall_cnt +1 on each edge with stall=1 & flush=0 & reset=0.
//  - bubble_cnt +1 on each edge where flush=1, or load with ex_valid=0 (stall=0).
//  - Both counters saturate at all-ones; no wrap. stall+flush same edge: bubble counted, not stall.
// STRUCTURE
//  - Shared package cpu_pipe_pkg: STAT_W, bit positions Z=0/N=1/V=2, ex_mem_t packed struct
//    (alu,status,b,vsel,write_num,write,mem_rd,mem_wr), VSEL encodings.
//  - One sub-module: sat_counter (CNT_W, inc, clk, reset) instantiated twice.
//  - Stage register itself is one always_ff on ex_mem_t plus valid; hazard logic in always_comb.
// TESTING
//  - reset high 2 cycles with random ex_* -> all mem_*, fwd_*, load_use, counters = 0.
//  - load ex_alu=16'h1234, write_num=3, write=1, valid=1; id_rs_a=3 -> next cycle mem_alu=16'h1234,
//    fwd_a_hit=1, fwd_b_hit=0, fwd_data=16'h1234.
//  - load ex_mem_rd=1, write=1, write_num=5, id_rs_b=5 -> load_use=1, fwd_b_hit=0; raise stall 3 cycles
//    -> mem_* unchanged, load_use stays 1, stall_cnt=3.
//  - stall=1 & flush=1 same edge with valid write pending -> mem_valid=0, mem_write=0, bubble_cnt+1,
//    stall_cnt unchanged; fwd hits drop to 0.
//  - ex_valid=0 with ex_write=1 -> mem_write=0, bubble_cnt+1; force counter to 16'hFFFF -> stays 16'hFFFF.
//  - reset asserted while stall=1 mid-sequence -> state and counters cleared that edge.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the pipelined CPU stage registers.
// EX->MEM slot layout, status bit positions and write-back select codes.
package cpu_pipe_pkg;

    localparam int DATA_W = 16;
    localparam int RN_W   = 3;
    localparam int VSEL_W = 2;
    localparam int STAT_W = 3;
    localparam int CNT_W  = 16;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;

    typedef enum logic [VSEL_W-1:0] {
        VSEL_ALU = 2'd0,
        VSEL_MEM = 2'd1,
        VSEL_PC  = 2'd2,
        VSEL_IMM = 2'd3
    } vsel_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [STAT_W-1:0] status;
        logic [DATA_W-1:0] b;
        logic [VSEL_W-1:0] vsel;
        logic [RN_W-1:0]   write_num;
        logic              write;
        logic              mem_rd;
        logic              mem_wr;
    } ex_mem_t;

    function automatic logic rn_match(
        input logic [RN_W-1:0] a,
        input logic [RN_W-1:0] b
    );
        return a == b;
    endfunction

endpackage

// File: rtl/ex_mem_stage_reg_sat_counter.sv
// Saturating up-counter used for stage performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with valid, stall/flush, operand forwarding,
// load-use detection and saturating stall/bubble counters.
module ex_mem_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RN_W   = 3,
    parameter int VSEL_W = 2,
    parameter int STAT_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [STAT_W-1:0] ex_status,
    input  logic [DATA_W-1:0] ex_b,
    input  logic [VSEL_W-1:0] ex_vsel,
    input  logic [RN_W-1:0]   ex_write_num,
    input  logic              ex_write,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              stall,
    input  logic              flush,
    input  logic [RN_W-1:0]   id_rs_a,
    input  logic [RN_W-1:0]   id_rs_b,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu,
    output logic [STAT_W-1:0] mem_status,
    output logic [DATA_W-1:0] mem_b,
    output logic [VSEL_W-1:0] mem_vsel,
    output logic [RN_W-1:0]   mem_write_num,
    output logic              mem_write,
    output logic              mem_mem_rd,
    output logic              mem_mem_wr,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_use,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ex_mem_t slot_q;
    ex_mem_t slot_d;
    logic    valid_q;
    logic    stall_inc;
    logic    bubble_inc;
    logic    hit_a;
    logic    hit_b;

    // Enables are qualified by valid at capture so MEM never sees a ghost op.
    always_comb begin
        slot_d           = '0;
        slot_d.alu       = ex_alu;
        slot_d.status    = ex_status;
        slot_d.b         = ex_b;
        slot_d.vsel      = ex_vsel;
        slot_d.write_num = ex_write_num;
        slot_d.write     = ex_valid & ex_write;
        slot_d.mem_rd    = ex_valid & ex_mem_rd;
        slot_d.mem_wr    = ex_valid & ex_mem_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q       <= 1'b0;
            slot_q.write  <= 1'b0;
            slot_q.mem_rd <= 1'b0;
            slot_q.mem_wr <= 1'b0;
        end else if (!stall) begin
            valid_q <= ex_valid;
            slot_q  <= slot_d;
        end
    end

    assign mem_valid     = valid_q;
    assign mem_alu       = slot_q.alu;
    assign mem_status    = slot_q.status;
    assign mem_b         = slot_q.b;
    assign mem_vsel      = slot_q.vsel;
    assign mem_write_num = slot_q.write_num;
    assign mem_write     = slot_q.write;
    assign mem_mem_rd    = slot_q.mem_rd;
    assign mem_mem_wr    = slot_q.mem_wr;
    assign fwd_data      = slot_q.alu;

    // A load's result is not known until MEM, so it stalls rather than forwards.
    always_comb begin
        hit_a     = rn_match(slot_q.write_num, id_rs_a);
        hit_b     = rn_match(slot_q.write_num, id_rs_b);
        fwd_a_hit = 1'b0;
        fwd_b_hit = 1'b0;
        load_use  = 1'b0;
        if (valid_q && slot_q.write) begin
            fwd_a_hit = !slot_q.mem_rd && hit_a;
            fwd_b_hit = !slot_q.mem_rd && hit_b;
            load_use  = slot_q.mem_rd && (hit_a || hit_b);
        end
    end

    assign stall_inc  = stall & ~flush;
    assign bubble_inc = flush | (~stall & ~ex_valid);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg: pipeline capture, hazards, counters.
// A narrow-counter second instance exercises saturation.
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [15:0] ex_alu;
    logic [2:0]  ex_status;
    logic [15:0] ex_b;
    logic [1:0]  ex_vsel;
    logic [2:0]  ex_write_num;
    logic        ex_write;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        stall;
    logic        flush;
    logic [2:0]  id_rs_a;
    logic [2:0]  id_rs_b;

    logic        mem_valid;
    logic [15:0] mem_alu;
    logic [2:0]  mem_status;
    logic [15:0] mem_b;
    logic [1:0]  mem_vsel;
    logic [2:0]  mem_write_num;
    logic        mem_write;
    logic        mem_mem_rd;
    logic        mem_mem_wr;
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [15:0] fwd_data;
    logic        load_use;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;

    logic        s_valid;
    logic [15:0] s_alu;
    logic [2:0]  s_status;
    logic [15:0] s_b;
    logic [1:0]  s_vsel;
    logic [2:0]  s_write_num;
    logic        s_write;
    logic        s_mem_rd;
    logic        s_mem_wr;
    logic        s_fwd_a;
    logic        s_fwd_b;
    logic [15:0] s_fwd_data;
    logic        s_load_use;
    logic [3:0]  s_stall_cnt;
    logic [3:0]  s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu        (ex_alu),
        .ex_status     (ex_status),
        .ex_b          (ex_b),
        .ex_vsel       (ex_vsel),
        .ex_write_num  (ex_write_num),
        .ex_write      (ex_write),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .stall         (stall),
        .flush         (flush),
        .id_rs_a       (id_rs_a),
        .id_rs_b       (id_rs_b),
        .mem_valid     (mem_valid),
        .mem_alu       (mem_alu),
        .mem_status    (mem_status),
        .mem_b         (mem_b),
        .mem_vsel      (mem_vsel),
        .mem_write_num (mem_write_num),
        .mem_write     (mem_write),
        .mem_mem_rd    (mem_mem_rd),
        .mem_mem_wr    (mem_mem_wr),
        .fwd_a_hit     (fwd_a_hit),
        .fwd_b_hit     (fwd_b_hit),
        .fwd_data      (fwd_data),
        .load_use      (load_use),
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    ex_mem_stage_reg #(
        .CNT_W (4)
    ) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu        (ex_alu),
        .ex_status     (ex_status),
        .ex_b          (ex_b),
        .ex_vsel       (ex_vsel),
        .ex_write_num  (ex_write_num),
        .ex_write      (ex_write),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .stall         (stall),
        .flush         (flush),
        .id_rs_a       (id_rs_a),
        .id_rs_b       (id_rs_b),
        .mem_valid     (s_valid),
        .mem_alu       (s_alu),
        .mem_status    (s_status),
        .mem_b         (s_b),
        .mem_vsel      (s_vsel),
        .mem_write_num (s_write_num),
        .mem_write     (s_write),
        .mem_mem_rd    (s_mem_rd),
        .mem_mem_wr    (s_mem_wr),
        .fwd_a_hit     (s_fwd_a),
        .fwd_b_hit     (s_fwd_b),
        .fwd_data      (s_fwd_data),
        .load_use      (s_load_use),
        .stall_cnt     (s_stall_cnt),
        .bubble_cnt    (s_bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [15:0] alu,
                          input logic [2:0] num, input logic w,
                          input logic rd, input logic wr);
        ex_valid     = v;
        ex_alu       = alu;
        ex_write_num = num;
        ex_write     = w;
        ex_mem_rd    = rd;
        ex_mem_wr    = wr;
    endtask

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        ex_valid     = 1'($urandom);
        ex_alu       = 16'($urandom);
        ex_status    = 3'($urandom);
        ex_b         = 16'($urandom);
        ex_vsel      = 2'($urandom);
        ex_write_num = 3'($urandom);
        ex_write     = 1'($urandom);
        ex_mem_rd    = 1'($urandom);
        ex_mem_wr    = 1'($urandom);
        id_rs_a      = 3'($urandom);
        id_rs_b      = 3'($urandom);
        step();
        step();
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_alu", 32'(mem_alu), 32'd0);
        check("rst_b", 32'(mem_b), 32'd0);
        check("rst_enables", {29'd0, mem_write, mem_mem_rd, mem_mem_wr}, 32'd0);
        check("rst_hazard", {29'd0, fwd_a_hit, fwd_b_hit, load_use}, 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);

        reset     = 1'b0;
        ex_status = 3'b010;
        ex_b      = 16'hBEEF;
        ex_vsel   = 2'd1;
        id_rs_a   = 3'd3;
        id_rs_b   = 3'd0;
        set_ex(1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b0);
        step();
        check("ld_alu", 32'(mem_alu), 32'h1234);
        check("ld_b", 32'(mem_b), 32'hBEEF);
        check("ld_status", 32'(mem_status), 32'h2);
        check("ld_valid", 32'(mem_valid), 32'd1);
        check("ld_write", 32'(mem_write), 32'd1);
        check("fwd_a", 32'(fwd_a_hit), 32'd1);
        check("fwd_b", 32'(fwd_b_hit), 32'd0);
        check("fwd_data", 32'(fwd_data), 32'h1234);
        check("ld_no_lu", 32'(load_use), 32'd0);

        id_rs_a = 3'd1;
        id_rs_b = 3'd5;
        set_ex(1'b1, 16'h0040, 3'd5, 1'b1, 1'b1, 1'b0);
        step();
        check("lu_hit", 32'(load_use), 32'd1);
        check("lu_fwd_b", 32'(fwd_b_hit), 32'd0);
        check("lu_fwd_a", 32'(fwd_a_hit), 32'd0);
        check("lu_mem_rd", 32'(mem_mem_rd), 32'd1);

        stall = 1'b1;
        set_ex(1'b1, 16'hDEAD, 3'd2, 1'b0, 1'b0, 1'b1);
        step();
        step();
        step();
        check("stl_alu", 32'(mem_alu), 32'h0040);
        check("stl_num", 32'(mem_write_num), 32'd5);
        check("stl_rd", 32'(mem_mem_rd), 32'd1);
        check("stl_lu", 32'(load_use), 32'd1);
        check("stl_cnt", 32'(stall_cnt), 32'd3);
        check("stl_bub", 32'(bubble_cnt), 32'd0);

        stall   = 1'b0;
        id_rs_a = 3'd4;
        id_rs_b = 3'd4;
        set_ex(1'b1, 16'h0100, 3'd4, 1'b0, 1'b0, 1'b1);
        step();
        check("st_wr", 32'(mem_mem_wr), 32'd1);
        check("st_nofwd", {30'd0, fwd_a_hit, fwd_b_hit}, 32'd0);
        check("st_nolu", 32'(load_use), 32'd0);

        id_rs_a = 3'd6;
        set_ex(1'b1, 16'h0777, 3'd6, 1'b1, 1'b0, 1'b0);
        step();
        check("pre_fl_fwd", 32'(fwd_a_hit), 32'd1);

        stall = 1'b1;
        flush = 1'b1;
        set_ex(1'b1, 16'h5555, 3'd6, 1'b1, 1'b0, 1'b0);
        step();
        check("fl_valid", 32'(mem_valid), 32'd0);
        check("fl_write", 32'(mem_write), 32'd0);
        check("fl_alu_hold", 32'(mem_alu), 32'h0777);
        check("fl_fwd", 32'(fwd_a_hit), 32'd0);
        check("fl_bub", 32'(bubble_cnt), 32'd1);
        check("fl_stl", 32'(stall_cnt), 32'd3);

        stall = 1'b0;
        flush = 1'b0;
        set_ex(1'b0, 16'h0ABC, 3'd6, 1'b1, 1'b0, 1'b0);
        step();
        check("bub_write", 32'(mem_write), 32'd0);
        check("bub_valid", 32'(mem_valid), 32'd0);
        check("bub_alu", 32'(mem_alu), 32'h0ABC);
        check("bub_cnt", 32'(bubble_cnt), 32'd2);

        stall = 1'b1;
        set_ex(1'b1, 16'h0001, 3'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check("sat_stl_main", 32'(stall_cnt), 32'd23);
        check("sat_stl_small", 32'(s_stall_cnt), 32'hF);

        stall = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat_bub_main", 32'(bubble_cnt), 32'd22);
        check("sat_bub_small", 32'(s_bubble_cnt), 32'hF);
        check("sat_stl_hold", 32'(s_stall_cnt), 32'hF);

        flush   = 1'b0;
        id_rs_a = 3'd3;
        set_ex(1'b1, 16'h4321, 3'd3, 1'b1, 1'b0, 1'b0);
        step();
        check("pre_rst_fwd", 32'(fwd_a_hit), 32'd1);

        stall = 1'b1;
        reset = 1'b1;
        step();
        check("mrst_valid", 32'(mem_valid), 32'd0);
        check("mrst_alu", 32'(mem_alu), 32'd0);
        check("mrst_fwd", 32'(fwd_a_hit), 32'd0);
        check("mrst_stl", 32'(stall_cnt), 32'd0);
        check("mrst_bub", 32'(bubble_cnt), 32'd0);

        reset = 1'b0;
        step();
        check("post_rst_stl", 32'(stall_cnt), 32'd1);
        check("post_rst_hold", 32'(mem_alu), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
